snoop_bus_controller: RTL and testbench



---
 rtl/snoop_pkg.sv | 24 ++
 rtl/snoop_bus_controller_rr_arbiter.sv | 34 +++
 rtl/snoop_bus_controller.sv | 134 +++++++++++++
 tb/tb_snoop_bus_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_pkg.sv
`default_nettype none
// snoop_pkg: bus message codes, MESI state codes and controller states. Rev 1.0
package snoop_pkg;

  localparam logic [1:0] MSG_NONE       = 2'b00;
  localparam logic [1:0] MSG_READ_MISS  = 2'b01;
  localparam logic [1:0] MSG_WRITE_MISS = 2'b10;
  localparam logic [1:0] MSG_INVALIDATE = 2'b11;

  localparam logic [1:0] MESI_EXCLUSIVE = 2'b10;
  localparam logic [1:0] MESI_SHARED    = 2'b01;
  localparam logic [1:0] MESI_INVALID   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BCAST  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5
  } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/snoop_bus_controller_rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick of the first requester at or after pointer. Rev 1.0
module rr_arbiter #(
  parameter  int N_CACHES = 4,
  localparam int IW       = $clog2(N_CACHES)
) (
  input  logic [N_CACHES-1:0] req,
  input  logic [IW-1:0]       pointer,
  output logic [N_CACHES-1:0] grant,
  output logic [IW-1:0]       index,
  output logic                valid
);

  logic [IW-1:0] cand;

  // Scan from the far end so the candidate closest to pointer is written last and wins.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N_CACHES - 1; k >= 0; k--) begin
      cand = IW'((int'(pointer) + k) % N_CACHES);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        index       = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_controller.sv
`default_nettype none
// snoop_bus_controller: owns the shared MESI snoop bus, arbitrates, broadcasts and sequences
// memory or cache-to-cache completion for the granted cache. Rev 1.0
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter  int N_CACHES     = 4,
  parameter  int SNOOP_CYCLES = 1,
  localparam int IW           = $clog2(N_CACHES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_CACHES-1:0]   req,
  input  logic [2*N_CACHES-1:0] req_msg,
  output logic [N_CACHES-1:0]   grant,
  output logic [1:0]            bus,
  output logic [IW-1:0]         bus_src,
  input  logic [N_CACHES-1:0]   snoop_wb,
  input  logic [N_CACHES-1:0]   snoop_abort,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack,
  input  logic                  wb_done,
  output logic [N_CACHES-1:0]   done,
  output logic                  err_illegal
);

  bus_state_e            state, state_nx;
  logic [1:0]            msg;
  logic [2:0]            cnt;
  logic [IW-1:0]         ptr;
  logic [N_CACHES-1:0]   arb_grant;
  logic [IW-1:0]         arb_index;
  logic                  arb_valid;
  logic [1:0]            arb_msg;
  logic                  start;
  logic                  supply;
  logic                  bcast_last;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(N_CACHES - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_arbiter #(.N_CACHES(N_CACHES)) u_arb (
    .req     (req),
    .pointer (ptr),
    .grant   (arb_grant),
    .index   (arb_index),
    .valid   (arb_valid)
  );

  assign arb_msg    = req_msg[{arb_index, 1'b0} +: 2];
  // Holding off while done pulses guarantees an idle cycle between transactions.
  assign start      = (state == ST_IDLE) && arb_valid && (done == '0);
  // A supplier flags either wb or abort; the owner's own response is ignored.
  assign supply     = |((snoop_abort | snoop_wb) & ~grant);
  assign bcast_last = (cnt == 3'(SNOOP_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start && (arb_msg != MSG_NONE)) state_nx = ST_BCAST;
      ST_BCAST:  if (bcast_last) state_nx = ST_SAMPLE;
      ST_SAMPLE: begin
        if (msg == MSG_INVALIDATE) state_nx = ST_DONE;
        else if (supply)           state_nx = ST_WB;
        else                       state_nx = ST_MEM;
      end
      ST_MEM:    if (mem_ack) state_nx = ST_DONE;
      ST_WB:     if (wb_done) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus     = MSG_NONE;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      ST_BCAST, ST_SAMPLE, ST_WB: bus = msg;
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (msg == MSG_WRITE_MISS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      bus_src     <= '0;
      msg         <= MSG_NONE;
      cnt         <= '0;
      ptr         <= '0;
      done        <= '0;
      err_illegal <= 1'b0;
    end else begin
      done        <= '0;
      err_illegal <= 1'b0;
      if ((state_nx == ST_DONE) && (state != ST_DONE)) done <= grant;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_src <= arb_index;
            if (arb_msg == MSG_NONE) begin
              err_illegal <= 1'b1;
              done        <= arb_grant;
              ptr         <= wrap_inc(arb_index);
            end else begin
              grant <= arb_grant;
              msg   <= arb_msg;
              cnt   <= '0;
            end
          end
        end
        ST_BCAST: cnt <= cnt + 3'd1;
        ST_DONE: begin
          grant <= '0;
          ptr   <= wrap_inc(bus_src);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_controller.sv
`default_nettype none
// tb_snoop_bus_controller: randomized rounds checked by a queue scoreboard and monitor. Rev 1.0
module tb_snoop_bus_controller;

  localparam int N = 4;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [2*N-1:0] req_msg;
  logic [N-1:0] grant;
  logic [1:0]   bus;
  logic [1:0]   bus_src;
  logic [N-1:0] snoop_wb = '0;
  logic [N-1:0] snoop_abort = '0;
  logic         mem_req;
  logic         mem_we;
  logic         mem_ack = 1'b0;
  logic         wb_done = 1'b0;
  logic [N-1:0] done;
  logic         err_illegal;

  snoop_bus_controller #(.N_CACHES(N), .SNOOP_CYCLES(S)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_msg     (req_msg),
    .grant       (grant),
    .bus         (bus),
    .bus_src     (bus_src),
    .snoop_wb    (snoop_wb),
    .snoop_abort (snoop_abort),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .wb_done     (wb_done),
    .done        (done),
    .err_illegal (err_illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       owner;
    bit [1:0] msg;
    bit       illegal;
    bit       mem;
    bit       we;
    bit       wb;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         plan_sup[N];
  logic [1:0] plan_msg[N];
  int         m_ptr = 0;
  bit         hold_mem = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Snoop receivers, memory and supplier cache behaviour.
  int bc = 0;
  int dly = -1;
  always @(negedge clock) begin
    mem_ack     = 1'b0;
    wb_done     = 1'b0;
    snoop_abort = '0;
    snoop_wb    = '0;
    for (int i = 0; i < N; i++)
      if (grant[i] && plan_sup[i] >= 0) begin
        snoop_abort[plan_sup[i]] = 1'b1;
        snoop_wb[plan_sup[i]]    = 1'b1;
      end
    if (!reset_n) begin
      bc  = 0;
      dly = -1;
    end else begin
      bc = (bus != 2'b00) ? bc + 1 : 0;
      if (hold_mem) begin
        dly = -1;
      end else if (mem_req || bc > S + 1) begin
        if (dly < 0) dly = int'($urandom_range(0, 3));
        if (dly == 0) begin
          if (mem_req) mem_ack = 1'b1;
          else         wb_done = 1'b1;
          if ($urandom_range(0, 2) == 0) begin
            mem_ack = 1'b1;
            wb_done = 1'b1;
          end
          dly = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
        if ($urandom_range(0, 9) == 0) mem_ack = 1'b1;
        if ($urandom_range(0, 9) == 0) wb_done = 1'b1;
      end
    end
  end

  // Monitor: accumulate what the bus did, compare against the scoreboard on each completion.
  int       bus_cyc = 0;
  bit       saw_mem = 0;
  bit       saw_we = 0;
  bit       src_bad = 0;
  bit       prev_done = 0;
  bit [1:0] last_bus = 0;
  int       gidx;
  exp_t     e;
  always @(negedge clock) begin
    if (!reset_n) begin
      bus_cyc = 0; saw_mem = 0; saw_we = 0; src_bad = 0; prev_done = 0; last_bus = 0;
    end else begin
      if (prev_done) chk("idle_gap_grant", int'(grant), 0);
      if (bus != 2'b00) begin
        bus_cyc++;
        last_bus = bus;
      end
      if (mem_req) begin
        saw_mem = 1;
        if (mem_we) saw_we = 1;
      end
      if (grant != '0) begin
        gidx = 0;
        for (int i = 0; i < N; i++) if (grant[i]) gidx = i;
        if (int'(bus_src) != gidx) src_bad = 1;
      end
      prev_done = (done != '0);
      if (done != '0 || err_illegal) begin
        if (q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          e = q.pop_front();
          chk("done_owner", int'(done), 1 << e.owner);
          chk("err_illegal", int'(err_illegal), int'(e.illegal));
          chk("mem_issued", int'(saw_mem), int'(e.mem));
          if (e.mem) chk("mem_we", int'(saw_we), int'(e.we));
          if (e.illegal) begin
            chk("illegal_bus_cycles", bus_cyc, 0);
            chk("illegal_grant", int'(grant), 0);
          end else begin
            chk("bus_msg", int'(last_bus), int'(e.msg));
            chk("grant_in_done", int'(grant), 1 << e.owner);
            chk("bus_src", int'(src_bad), 0);
            chk("wb_path", int'(bus_cyc > S + 1), int'(e.wb));
            if (!e.wb) chk("bcast_cycles", bus_cyc, S + 1);
          end
        end
        bus_cyc = 0; saw_mem = 0; saw_we = 0; src_bad = 0; last_bus = 0;
      end
    end
  end

  // Reference: with all requests held, completions follow a cyclic scan from the pointer.
  task automatic run_round(input logic [N-1:0] set);
    int   cyc;
    int   start;
    int   i;
    exp_t x;
    start = m_ptr;
    for (int k = 0; k < N; k++) begin
      i = (start + k) % N;
      if (set[i]) begin
        x.owner   = i;
        x.msg     = plan_msg[i];
        x.illegal = (plan_msg[i] == 2'b00);
        x.wb      = !x.illegal && plan_msg[i] != 2'b11 && plan_sup[i] >= 0 && plan_sup[i] != i;
        x.mem     = !x.illegal && plan_msg[i] != 2'b11 && !x.wb;
        x.we      = x.mem && plan_msg[i] == 2'b10;
        q.push_back(x);
        m_ptr = (i + 1) % N;
      end
    end
    @(negedge clock);
    for (int j = 0; j < N; j++) req_msg[2*j +: 2] = plan_msg[j];
    req = set;
    cyc = 0;
    while (req != '0 && cyc < 2000) begin
      @(negedge clock);
      req = req & ~done;
      cyc++;
    end
    if (req != '0) begin
      errors++;
      $display("FAIL round_timeout: pending req %b required 0000", req);
      finish_now();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic plan_one(input int c, input logic [1:0] m, input int s);
    plan_msg[c] = m;
    plan_sup[c] = s;
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0;
    req     = '0;
    req_msg = '0;
    for (int i = 0; i < N; i++) begin
      plan_sup[i] = -1;
      plan_msg[i] = 2'b01;
    end
    repeat (3) @(negedge clock);
    chk("rst_grant", int'(grant), 0);
    chk("rst_bus", int'(bus), 0);
    chk("rst_bus_src", int'(bus_src), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_illegal), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    plan_one(0, 2'b01, -1);                      run_round(4'b0001);
    plan_one(1, 2'b10, 2);                       run_round(4'b0010);
    for (int i = 0; i < N; i++) plan_one(i, 2'b11, (i + 1) % N);
    run_round(4'b1111);
    plan_one(0, 2'b11, 0);                       run_round(4'b0001);
    plan_one(0, 2'b01, 0);                       run_round(4'b0001);
    plan_one(2, 2'b00, -1);                      run_round(4'b0100);
    plan_one(0, 2'b01, 1); plan_one(3, 2'b10, -1); run_round(4'b1001);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        plan_one(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, N)) - 1);
      run_round(4'($urandom_range(1, 15)));
    end
    chk("queue_drained", q.size(), 0);

    // Asynchronous reset mid-transaction; leave the pointer away from 0 first.
    plan_one(1, 2'b01, -1);                      run_round(4'b0010);
    hold_mem = 1'b1;
    plan_one(2, 2'b01, -1);
    req_msg[5:4] = 2'b01;
    req = 4'b0100;
    cyc = 0;
    while (!mem_req && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    chk("reached_mem", int'(mem_req), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_mem_req", int'(mem_req), 0);
    chk("async_grant", int'(grant), 0);
    chk("async_bus", int'(bus), 0);
    req = '0;
    hold_mem = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_ptr = 0;
    @(negedge clock);
    chk("post_rst_grant", int'(grant), 0);
    for (int i = 0; i < N; i++) plan_one(i, 2'b11, -1);
    run_round(4'b1111);
    chk("final_queue", q.size(), 0);
    finish_now();
  end

endmodule
`default_nettype wire
